div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage initiator for the iterative divider (`div`).
- Accepts DIV/DIVU/REM/REMU requests from the EX stage.
- Resolves RISC-V special cases (divide-by-zero, signed overflow, rd=x0) locally, without starting the divider.
- Otherwise drives the divider's start/operand handshake, stalls the pipeline until the result returns, then emits a one-cycle register-file write.

Parameters:
- XLEN, 32, operand/result width (matches `RegBus`).
- FAST_SPECIAL, 1, 1 = resolve special cases locally; 0 = send every request with rd≠0 to the divider.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- req_valid_i  in  1  EX-stage request valid
- op_i  in  3  funct3; 100 DIV, 101 DIVU, 110 REM, 111 REMU; op_i[2]=0 is not a divide op
- rs1_data_i  in  XLEN  dividend
- rs2_data_i  in  XLEN  divisor
- rd_addr_i  in  5  destination register
- flush_i  in  1  pipeline flush (jump/trap)
- stall_o  out  1  hold the front pipeline
- wb_we_o  out  1  register-file write enable
- wb_waddr_o  out  5  write address
- wb_wdata_o  out  XLEN  write data
- div_start_o  out  1  divider start, level-held
- div_dividend_o  out  XLEN  registered operand
- div_divisor_o  out  XLEN  registered operand
- div_op_o  out  3  registered op
- div_reg_waddr_o  out  5  registered rd tag
- div_result_i  in  XLEN  divider result
- div_ready_i  in  1  divider result valid
- div_busy_i  in  1  divider busy
- div_reg_waddr_i  in  5  tag returned with result

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0; operand registers 0. Reset mid-operation aborts with no writeback; div_start_o is 0 the next cycle.
- States: IDLE, BUSY, WB, DRAIN.
- IDLE, accept rule: accepts when req_valid_i=1 and op_i[2]=1. Ignores req_valid_i with op_i[2]=0. Ignores requests in any state other than IDLE.
- IDLE, rd_addr_i=0: go to WB, wb_we_o stays 0, divider not started.
- IDLE, special case (FAST_SPECIAL=1 and rd≠0): latch the local result and go to WB.
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- IDLE, otherwise: register operands, op and rd into the div_*_o registers, go to BUSY.
- BUSY:
  - div_start_o=1, operands held stable.
  - div_ready_i=1 with div_reg_waddr_i == latched rd: capture div_result_i, go to WB; div_start_o=0 in WB.
  - div_ready_i with a mismatched tag: ignored.
- WB:
  - Exactly one cycle: wb_we_o=(rd≠0), wb_waddr_o=rd, wb_wdata_o=result.
  - Then IDLE.
- stall_o (combinational):
  - 1 in BUSY.
  - 1 in IDLE while an accepted request is present.
  - 0 in WB and DRAIN.
  - Resulting latency: special/x0 case = 1 stall cycle, write in the following cycle. Divider path = stall from accept until the cycle after ready, write in that cycle.
- flush_i:
  - In IDLE: suppresses accept.
  - In BUSY: div_start_o drops next cycle, no writeback. Go to DRAIN if div_busy_i=1, else IDLE.
  - In WB: suppresses wb_we_o, return to IDLE.
  - Flush and ready in the same BUSY cycle: flush wins, result discarded.
- DRAIN: div_start_o=0; stay until div_busy_i=0, then IDLE. No new request is issued while the divider is still busy.
- Widths: signed checks use XLEN-bit two's complement; no sign/abs conversion here; the divider owns the signed arithmetic.

Decomposition:
- Shared package/defines:
  - funct3 constants: DIV 3'b100, DIVU 3'b101, REM 3'b110, REMU 3'b111.
  - FSM state encodings.
  - Reuse existing `RegBus` and `RegAddrBus`.
- One combinational sub-module, div_special_case: inputs op, dividend, divisor; outputs is_special and special_result.

Test Plan:
- Divider path, DIV: op=100, 10 / 3, rd=18 → div_start_o held with stable operands until ready tag 18. Then one-cycle wb_we_o=1, waddr=18, wdata=0x00000003. stall_o low in the WB cycle.
- Signed divide and remainder:
  - DIV -10 (0xFFFFFFF6) / 3 → wdata 0xFFFFFFFD.
  - REM -10 / 3 → 0xFFFFFFFF.
  - REM 10 / -3 → 0x00000001.
  - REM -10 / -3 → 0xFFFFFFFF.
- Special cases, divider never started:
  - DIVU x / 0 → 0xFFFFFFFF.
  - REMU 7 / 0 → 0x00000007.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - Each writes after exactly 1 stall cycle; div_start_o remains 0.
- rd=0 request → no divider start, no wb_we_o, stall_o high for one cycle only.
- flush_i 5 cycles into BUSY while div_busy_i=1:
  - div_start_o drops, no writeback.
  - A new request is not accepted (stall_o=0, no accept) until div_busy_i=0.
  - Then 10 / 3 completes correctly.
- rst low mid-BUSY → all outputs 0 next cycle. Stale div_ready_i after release produces no write. Mismatched-tag ready in BUSY is ignored.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants for the divider issue controller: bus widths, funct3 encodings, FSM states.
package div_issue_ctrl_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;

    localparam logic [2:0] OpDiv  = 3'b100;
    localparam logic [2:0] OpDivu = 3'b101;
    localparam logic [2:0] OpRem  = 3'b110;
    localparam logic [2:0] OpRemu = 3'b111;

    // funct3 bit meanings within the divide group
    localparam int unsigned OpIsDivBit    = 2;
    localparam int unsigned OpIsRemBit    = 1;
    localparam int unsigned OpUnsignedBit = 0;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
    localparam logic [1:0] StWb    = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

endpackage

// File: rtl/div_special_case.sv
// Detects RISC-V divide special cases (divide-by-zero, signed overflow) and their fixed results.
module div_special_case
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = RegBus
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            is_special,
    output logic [XLEN-1:0] special_result
);

    logic div_zero;
    logic overflow;

    assign div_zero = (divisor == '0);
    assign overflow = !op[OpUnsignedBit] &&
                      (dividend == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (divisor == '1);

    assign is_special = op[OpIsDivBit] && (div_zero || overflow);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = op[OpIsRemBit] ? dividend : '1;
        end else if (overflow) begin
            special_result = op[OpIsRemBit] ? '0 : dividend;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider: resolves special cases locally, otherwise
// issues to the divider, stalls until the tagged result returns, then writes back one cycle.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = RegBus,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic [RegAddrBus-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  wb_we_o,
    output logic [RegAddrBus-1:0] wb_waddr_o,
    output logic [XLEN-1:0]       wb_wdata_o,
    output logic                  div_start_o,
    output logic [XLEN-1:0]       div_dividend_o,
    output logic [XLEN-1:0]       div_divisor_o,
    output logic [2:0]            div_op_o,
    output logic [RegAddrBus-1:0] div_reg_waddr_o,
    input  logic [XLEN-1:0]       div_result_i,
    input  logic                  div_ready_i,
    input  logic                  div_busy_i,
    input  logic [RegAddrBus-1:0] div_reg_waddr_i
);

    logic [1:0]            state_q, state_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [XLEN-1:0]       dividend_q, dividend_d;
    logic [XLEN-1:0]       divisor_q, divisor_d;
    logic [2:0]            op_q, op_d;
    logic [RegAddrBus-1:0] tag_q, tag_d;
    logic [RegAddrBus-1:0] rd_q, rd_d;

    logic            accept;
    logic            is_special;
    logic [XLEN-1:0] special_result;

    div_special_case #(
        .XLEN(XLEN)
    ) u_special (
        .op            (op_i),
        .dividend      (rs1_data_i),
        .divisor       (rs2_data_i),
        .is_special    (is_special),
        .special_result(special_result)
    );

    assign accept = (state_q == StIdle) && req_valid_i && op_i[OpIsDivBit] && !flush_i;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        op_d       = op_q;
        tag_d      = tag_q;
        rd_d       = rd_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWb;
                    if (rd_addr_i == '0) begin
                        // x0 destination: nothing to compute, pass through WB without a write
                        rd_d     = '0;
                        result_d = '0;
                    end else if (FAST_SPECIAL && is_special) begin
                        rd_d     = rd_addr_i;
                        result_d = special_result;
                    end else begin
                        rd_d       = rd_addr_i;
                        tag_d      = rd_addr_i;
                        dividend_d = rs1_data_i;
                        divisor_d  = rs2_data_i;
                        op_d       = op_i;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush_i) begin
                    state_d = div_busy_i ? StDrain : StIdle;
                end else if (div_ready_i && (div_reg_waddr_i == tag_q)) begin
                    result_d = div_result_i;
                    state_d  = StWb;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                if (!div_busy_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            result_q   <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            rd_q       <= rd_d;
        end
    end

    assign stall_o         = (state_q == StBusy) || accept;
    assign div_start_o     = (state_q == StBusy);
    assign div_dividend_o  = dividend_q;
    assign div_divisor_o   = divisor_q;
    assign div_op_o        = op_q;
    assign div_reg_waddr_o = tag_q;

    assign wb_we_o    = (state_q == StWb) && (rd_q != '0) && !flush_i;
    assign wb_waddr_o = (state_q == StWb) ? rd_q : '0;
    assign wb_wdata_o = (state_q == StWb) ? result_q : '0;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench plays the divider and supplies known results.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        stall_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        div_start_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [2:0]  div_op_o;
    logic [4:0]  div_reg_waddr_o;
    logic [31:0] div_result_i;
    logic        div_ready_i;
    logic        div_busy_i;
    logic [4:0]  div_reg_waddr_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .XLEN        (32),
        .FAST_SPECIAL(1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .op_i           (op_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .wb_we_o        (wb_we_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_wdata_o     (wb_wdata_o),
        .div_start_o    (div_start_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_op_o       (div_op_o),
        .div_reg_waddr_o(div_reg_waddr_o),
        .div_result_i   (div_result_i),
        .div_ready_i    (div_ready_i),
        .div_busy_i     (div_busy_i),
        .div_reg_waddr_i(div_reg_waddr_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        req_valid_i = 1'b1;
        op_i        = op;
        rs1_data_i  = a;
        rs2_data_i  = b;
        rd_addr_i   = rd;
    endtask

    // Divider path: accept, a few BUSY cycles, optional stray-tag ready, matching ready, WB.
    task automatic do_div(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                          input bit stray);
        request(op, a, b, rd);
        #1;
        check({nm, "/acc_stall"}, 32'(stall_o), 32'd1);
        check({nm, "/acc_start"}, 32'(div_start_o), 32'd0);
        step();
        req_valid_i = 1'b0;
        div_busy_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check({nm, "/busy_start"}, 32'(div_start_o), 32'd1);
            check({nm, "/busy_dvd"}, div_dividend_o, a);
            check({nm, "/busy_dvs"}, div_divisor_o, b);
            check({nm, "/busy_op"}, 32'(div_op_o), 32'(op));
            check({nm, "/busy_tag"}, 32'(div_reg_waddr_o), 32'(rd));
            check({nm, "/busy_stall"}, 32'(stall_o), 32'd1);
            step();
        end
        if (stray) begin
            div_ready_i     = 1'b1;
            div_reg_waddr_i = rd ^ 5'd1;
            div_result_i    = 32'hDEAD_BEEF;
            step();
            div_ready_i = 1'b0;
            #1;
            check({nm, "/stray_start"}, 32'(div_start_o), 32'd1);
            check({nm, "/stray_we"}, 32'(wb_we_o), 32'd0);
            step();
        end
        div_ready_i     = 1'b1;
        div_reg_waddr_i = rd;
        div_result_i    = res;
        #1;
        check({nm, "/rdy_stall"}, 32'(stall_o), 32'd1);
        check({nm, "/rdy_we"}, 32'(wb_we_o), 32'd0);
        step();
        div_ready_i = 1'b0;
        div_busy_i  = 1'b0;
        #1;
        check({nm, "/wb_we"}, 32'(wb_we_o), 32'd1);
        check({nm, "/wb_waddr"}, 32'(wb_waddr_o), 32'(rd));
        check({nm, "/wb_wdata"}, wb_wdata_o, res);
        check({nm, "/wb_stall"}, 32'(stall_o), 32'd0);
        check({nm, "/wb_start"}, 32'(div_start_o), 32'd0);
        step();
        #1;
        check({nm, "/post_we"}, 32'(wb_we_o), 32'd0);
    endtask

    // Locally resolved request: one stall cycle, write (or not, for x0) the next cycle.
    task automatic do_local(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                            input logic exp_we);
        request(op, a, b, rd);
        #1;
        check({nm, "/acc_stall"}, 32'(stall_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        #1;
        check({nm, "/wb_we"}, 32'(wb_we_o), 32'(exp_we));
        check({nm, "/wb_waddr"}, 32'(wb_waddr_o), 32'(rd));
        check({nm, "/wb_wdata"}, wb_wdata_o, exp);
        check({nm, "/wb_stall"}, 32'(stall_o), 32'd0);
        check({nm, "/wb_start"}, 32'(div_start_o), 32'd0);
        step();
        #1;
        check({nm, "/post_we"}, 32'(wb_we_o), 32'd0);
        check({nm, "/post_start"}, 32'(div_start_o), 32'd0);
    endtask

    initial begin
        rst             = 1'b0;
        req_valid_i     = 1'b0;
        op_i            = 3'b000;
        rs1_data_i      = '0;
        rs2_data_i      = '0;
        rd_addr_i       = '0;
        flush_i         = 1'b0;
        div_result_i    = '0;
        div_ready_i     = 1'b0;
        div_busy_i      = 1'b0;
        div_reg_waddr_i = '0;
        step();
        step();
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_start", 32'(div_start_o), 32'd0);
        check("rst_dvd", div_dividend_o, 32'd0);
        check("rst_tag", 32'(div_reg_waddr_o), 32'd0);
        rst = 1'b1;
        step();

        do_div("div_10_3", OpDiv, 32'd10, 32'd3, 5'd18, 32'h0000_0003, 1'b0);
        do_div("div_m10_3", OpDiv, 32'hFFFF_FFF6, 32'd3, 5'd4, 32'hFFFF_FFFD, 1'b0);
        do_div("rem_m10_3", OpRem, 32'hFFFF_FFF6, 32'd3, 5'd5, 32'hFFFF_FFFF, 1'b0);
        do_div("rem_10_m3", OpRem, 32'd10, 32'hFFFF_FFFD, 5'd6, 32'h0000_0001, 1'b0);
        do_div("rem_m10_m3", OpRem, 32'hFFFF_FFF6, 32'hFFFF_FFFD, 5'd7, 32'hFFFF_FFFF, 1'b1);
        // Unsigned ops never take the signed-overflow shortcut
        do_div("divu_ovf", OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, 1'b0);

        do_local("divu_z", OpDivu, 32'h0000_1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b1);
        do_local("remu_z", OpRemu, 32'd7, 32'd0, 5'd11, 32'h0000_0007, 1'b1);
        do_local("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1);
        do_local("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1'b1);
        do_local("rd_x0", OpDiv, 32'd10, 32'd3, 5'd0, 32'h0000_0000, 1'b0);

        // Non-divide funct3 is ignored
        request(3'b011, 32'd10, 32'd3, 5'd14);
        #1;
        check("nondiv_stall", 32'(stall_o), 32'd0);
        step();
        req_valid_i = 1'b0;
        #1;
        check("nondiv_start", 32'(div_start_o), 32'd0);
        check("nondiv_we", 32'(wb_we_o), 32'd0);
        step();

        // Flush five cycles into BUSY, with a same-cycle matching ready that must be dropped
        request(OpDiv, 32'd10, 32'd3, 5'd20);
        step();
        req_valid_i = 1'b0;
        div_busy_i  = 1'b1;
        repeat (4) step();
        #1;
        check("fl_busy_start", 32'(div_start_o), 32'd1);
        flush_i         = 1'b1;
        div_ready_i     = 1'b1;
        div_reg_waddr_i = 5'd20;
        div_result_i    = 32'd3;
        #1;
        check("fl_cycle_we", 32'(wb_we_o), 32'd0);
        step();
        flush_i     = 1'b0;
        div_ready_i = 1'b0;
        #1;
        check("fl_drain_start", 32'(div_start_o), 32'd0);
        check("fl_drain_we", 32'(wb_we_o), 32'd0);
        request(OpDiv, 32'd10, 32'd3, 5'd21);
        #1;
        check("fl_drain_stall", 32'(stall_o), 32'd0);
        step();
        #1;
        check("fl_drain_noacc", 32'(div_start_o), 32'd0);
        check("fl_drain_we2", 32'(wb_we_o), 32'd0);
        check("fl_drain_stall2", 32'(stall_o), 32'd0);
        req_valid_i = 1'b0;
        div_busy_i  = 1'b0;
        step();
        #1;
        check("fl_idle_start", 32'(div_start_o), 32'd0);
        do_div("fl_after", OpDiv, 32'd10, 32'd3, 5'd21, 32'h0000_0003, 1'b0);

        // Reset mid-BUSY, then a stale ready after release
        request(OpDiv, 32'd100, 32'd7, 5'd22);
        step();
        req_valid_i = 1'b0;
        div_busy_i  = 1'b1;
        #1;
        check("rb_start", 32'(div_start_o), 32'd1);
        rst = 1'b0;
        step();
        div_busy_i = 1'b0;
        #1;
        check("rb_start0", 32'(div_start_o), 32'd0);
        check("rb_stall0", 32'(stall_o), 32'd0);
        check("rb_we0", 32'(wb_we_o), 32'd0);
        check("rb_dvd0", div_dividend_o, 32'd0);
        check("rb_dvs0", div_divisor_o, 32'd0);
        check("rb_op0", 32'(div_op_o), 32'd0);
        check("rb_tag0", 32'(div_reg_waddr_o), 32'd0);
        rst             = 1'b1;
        div_ready_i     = 1'b1;
        div_reg_waddr_i = 5'd22;
        div_result_i    = 32'd14;
        step();
        #1;
        check("stale_we", 32'(wb_we_o), 32'd0);
        check("stale_start", 32'(div_start_o), 32'd0);
        div_ready_i = 1'b0;
        step();
        #1;
        check("stale_we2", 32'(wb_we_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
